// File: rtl/plic_seq_pkg.sv
// Shared types and constants for the PLIC claim/complete sequencer.
package plic_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM_REQ,
    S_CLAIM_RESP,
    S_DELIVER,
    S_WAIT_EOI,
    S_CMPL_REQ,
    S_CMPL_RESP
  } seq_state_t;

  localparam logic [2:0] TL_GET      = 3'd4;
  localparam logic [2:0] TL_PUT_FULL = 3'd0;
  localparam logic [2:0] TL_ACK      = 3'd0;
  localparam logic [2:0] TL_ACK_DATA = 3'd1;

  localparam logic [27:0] CLAIM_OFFSET   = 28'h200004;
  localparam logic [27:0] CONTEXT_STRIDE = 28'h1000;

  function automatic logic [27:0] claim_addr(input logic [27:0] base, input int unsigned ctx);
    return base + CLAIM_OFFSET + 28'(ctx) * CONTEXT_STRIDE;
  endfunction

endpackage

// File: rtl/plic_seq_watchdog.sv
// D-response watchdog; only built when PLIC_CLAIM_SEQ_TIMEOUT_EN is defined.
`ifdef PLIC_CLAIM_SEQ_TIMEOUT_EN
module plic_seq_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  logic [15:0] r_count;

  // Count k is held k cycles after entry, so expiry fires on the LIMIT-th cycle.
  assign o_expired = i_run && (r_count >= 16'(LIMIT - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/plic_claim_sequencer.sv
// Hardware claim/complete sequencer for one PLIC context (TileLink-UL client).
// Optional D-response watchdog enabled by defining PLIC_CLAIM_SEQ_TIMEOUT_EN.
module plic_claim_sequencer
  import plic_seq_pkg::*;
#(
  parameter logic [27:0] BASE_ADDR      = 28'hC000000,
  parameter int unsigned CONTEXT        = 0,
  parameter logic [8:0]  SOURCE_ID      = 9'h1FF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        int_in,
  input  logic        a_ready,
  output logic        a_valid,
  output logic [2:0]  a_bits_opcode,
  output logic [2:0]  a_bits_param,
  output logic [1:0]  a_bits_size,
  output logic [8:0]  a_bits_source,
  output logic [27:0] a_bits_address,
  output logic [7:0]  a_bits_mask,
  output logic [63:0] a_bits_data,
  output logic        a_bits_corrupt,
  output logic        d_ready,
  input  logic        d_valid,
  input  logic [2:0]  d_bits_opcode,
  input  logic        d_bits_denied,
  input  logic [63:0] d_bits_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id,
  input  logic        eoi,
  output logic        busy,
  output logic [7:0]  spurious_cnt,
  output logic        err_denied,
  output logic        err_timeout
);

  localparam logic [27:0] REG_ADDR = claim_addr(BASE_ADDR, CONTEXT);

  seq_state_t  r_state;
  seq_state_t  w_next_state;
  logic [31:0] r_id;
  logic [7:0]  r_spurious_cnt;
  logic        r_err_denied;
  logic [31:0] w_claim_id;
  logic        w_d_fire;
  logic        w_timeout;

  assign w_claim_id = d_bits_data[63:32];
  assign w_d_fire   = d_ready && d_valid;

  // Response opcode and lower data word carry nothing this block acts on.
  logic w_unused;
  assign w_unused = ^{d_bits_opcode, d_bits_data[31:0]};

`ifdef PLIC_CLAIM_SEQ_TIMEOUT_EN
  logic w_wd_run;
  logic w_wd_clear;
  logic r_err_timeout;

  assign w_wd_run   = (r_state == S_CLAIM_RESP) || (r_state == S_CMPL_RESP);
  assign w_wd_clear = (w_next_state != r_state);

  plic_seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_run    (w_wd_run),
    .i_clear  (w_wd_clear),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout && !d_valid) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a real D beat takes priority over a coincident timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable && int_in) w_next_state = S_CLAIM_REQ;
      end
      S_CLAIM_REQ: begin
        if (a_ready) w_next_state = S_CLAIM_RESP;
      end
      S_CLAIM_RESP: begin
        if (d_valid) begin
          if (d_bits_denied || (w_claim_id == '0)) w_next_state = S_IDLE;
          else                                     w_next_state = S_DELIVER;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_DELIVER: begin
        if (id_ready) w_next_state = S_WAIT_EOI;
      end
      S_WAIT_EOI: begin
        if (eoi) w_next_state = S_CMPL_REQ;
      end
      S_CMPL_REQ: begin
        if (a_ready) w_next_state = S_CMPL_RESP;
      end
      S_CMPL_RESP: begin
        if (d_valid || w_timeout) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs; A fields are zero whenever no request is presented
  always_comb begin
    a_valid        = 1'b0;
    a_bits_opcode  = '0;
    a_bits_size    = '0;
    a_bits_address = '0;
    a_bits_mask    = '0;
    a_bits_data    = '0;
    d_ready        = 1'b0;
    id_valid       = 1'b0;
    case (r_state)
      S_CLAIM_REQ: begin
        a_valid        = 1'b1;
        a_bits_opcode  = TL_GET;
        a_bits_size    = 2'd2;
        a_bits_address = REG_ADDR;
        a_bits_mask    = 8'hF0;
      end
      S_CMPL_REQ: begin
        a_valid        = 1'b1;
        a_bits_opcode  = TL_PUT_FULL;
        a_bits_size    = 2'd2;
        a_bits_address = REG_ADDR;
        a_bits_mask    = 8'hF0;
        a_bits_data    = {r_id, 32'h0};
      end
      S_CLAIM_RESP, S_CMPL_RESP: d_ready  = 1'b1;
      S_DELIVER:                 id_valid = 1'b1;
      default: ;
    endcase
  end

  // Claimed ID, spurious counter and sticky denied flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id           <= '0;
      r_spurious_cnt <= '0;
      r_err_denied   <= 1'b0;
    end else if (w_d_fire) begin
      if (d_bits_denied) r_err_denied <= 1'b1;
      if (r_state == S_CLAIM_RESP) begin
        r_id <= w_claim_id;
        if (!d_bits_denied && (w_claim_id == '0) && (r_spurious_cnt != '1)) begin
          r_spurious_cnt <= r_spurious_cnt + 8'd1;
        end
      end
    end
  end

  assign a_bits_param   = '0;
  assign a_bits_source  = SOURCE_ID;
  assign a_bits_corrupt = 1'b0;
  assign id             = r_id;
  assign busy           = (r_state != S_IDLE);
  assign spurious_cnt   = r_spurious_cnt;
  assign err_denied     = r_err_denied;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Self-checking bench for plic_claim_sequencer: vector table, directed corners, random loop.
module tb_plic_claim_sequencer;
  import plic_seq_pkg::*;

  localparam logic [27:0] T_BASE   = 28'h0C00000;
  localparam int unsigned T_CTX    = 0;
  localparam logic [8:0]  T_SRC    = 9'h1FF;
  localparam logic [27:0] EXP_ADDR = 28'hE00004;

  logic        clock = 1'b0;
  logic        reset, enable, int_in, a_ready;
  logic        a_valid;
  logic [2:0]  a_bits_opcode, a_bits_param;
  logic [1:0]  a_bits_size;
  logic [8:0]  a_bits_source;
  logic [27:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        a_bits_corrupt, d_ready, d_valid;
  logic [2:0]  d_bits_opcode;
  logic        d_bits_denied;
  logic [63:0] d_bits_data;
  logic        id_valid, id_ready;
  logic [31:0] id;
  logic        eoi, busy;
  logic [7:0]  spurious_cnt;
  logic        err_denied, err_timeout;

  plic_claim_sequencer #(
    .BASE_ADDR     (T_BASE),
    .CONTEXT       (T_CTX),
    .SOURCE_ID     (T_SRC),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .int_in(int_in),
    .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode),
    .a_bits_param(a_bits_param), .a_bits_size(a_bits_size),
    .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
    .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data),
    .a_bits_corrupt(a_bits_corrupt), .d_ready(d_ready), .d_valid(d_valid),
    .d_bits_opcode(d_bits_opcode), .d_bits_denied(d_bits_denied),
    .d_bits_data(d_bits_data), .id_valid(id_valid), .id_ready(id_ready),
    .id(id), .eoi(eoi), .busy(busy), .spurious_cnt(spurious_cnt),
    .err_denied(err_denied), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int m_spur = 0;
  bit m_err  = 1'b0;

  typedef struct {
    logic [31:0] idv;
    bit          den;
    int          a_dly;
    int          d_dly;
    int          c_dly;
    bit          exp_deliver;
    logic [7:0]  exp_spur;
    bit          exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string name, input logic [2:0] opc, input logic [63:0] data);
    chk({name, "_valid"}, a_valid, 1);
    chk({name, "_opcode"}, a_bits_opcode, opc);
    chk({name, "_addr"}, a_bits_address, EXP_ADDR);
    chk({name, "_size"}, a_bits_size, 2);
    chk({name, "_mask"}, a_bits_mask, 8'hF0);
    chk({name, "_data"}, a_bits_data, data);
    chk({name, "_param"}, a_bits_param, 0);
    chk({name, "_source"}, a_bits_source, T_SRC);
    chk({name, "_corrupt"}, a_bits_corrupt, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_a_valid"}, a_valid, 0);
    chk({name, "_a_opcode"}, a_bits_opcode, 0);
    chk({name, "_a_addr"}, a_bits_address, 0);
    chk({name, "_a_size"}, a_bits_size, 0);
    chk({name, "_a_mask"}, a_bits_mask, 0);
    chk({name, "_a_data"}, a_bits_data, 0);
    chk({name, "_a_source"}, a_bits_source, T_SRC);
    chk({name, "_d_ready"}, d_ready, 0);
    chk({name, "_id_valid"}, id_valid, 0);
    chk({name, "_id"}, id, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_spur"}, spurious_cnt, 0);
    chk({name, "_err_denied"}, err_denied, 0);
    chk({name, "_err_timeout"}, err_timeout, 0);
  endtask

  // One full interrupt sequence as seen from the bus and consumer sides.
  task automatic run_claim(input logic [31:0] idv, input bit den, input int a_dly,
                           input int d_dly, input int c_dly, input int e_dly,
                           input bit put_den, input bit abort_wait, output bit delivered);
    delivered = 1'b0;
    enable = 1'b1;
    int_in = 1'b1;
    step();
    int_in = 1'b0;
    check_a("get", TL_GET, 64'h0);
    for (int i = 0; i < a_dly; i++) begin
      step();
      check_a("get_hold", TL_GET, 64'h0);
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    chk("get_single", a_valid, 0);
    chk("claim_d_ready", d_ready, 1);
    for (int i = 0; i < d_dly; i++) begin
      step();
      chk("claim_wait_d_ready", d_ready, 1);
      chk("claim_wait_a_valid", a_valid, 0);
    end
    d_valid = 1'b1;
    d_bits_opcode = TL_ACK_DATA;
    d_bits_data = {idv, 32'hDEAD_BEEF};
    d_bits_denied = den;
    step();
    d_valid = 1'b0;
    d_bits_denied = 1'b0;
    if (den) m_err = 1'b1;
    else if (idv == 0) m_spur = (m_spur < 255) ? m_spur + 1 : 255;
    chk("spurious_cnt", spurious_cnt, 64'(m_spur));
    chk("err_denied", err_denied, 64'(m_err));
    if (den || idv == 0) begin
      chk("no_deliver_busy", busy, 0);
      chk("no_deliver_id_valid", id_valid, 0);
      chk("no_deliver_a_valid", a_valid, 0);
      return;
    end
    chk("deliver_id_valid", id_valid, 1);
    chk("deliver_id", id, 64'(idv));
    for (int i = 0; i < c_dly; i++) begin
      eoi = (i == 0);
      d_valid = (i == 0);
      chk("deliver_d_ready", d_ready, 0);
      step();
      eoi = 1'b0;
      d_valid = 1'b0;
      chk("deliver_hold", id_valid, 1);
      chk("deliver_no_put", a_valid, 0);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    delivered = 1'b1;
    chk("wait_id_valid", id_valid, 0);
    chk("wait_a_valid", a_valid, 0);
    chk("wait_busy", busy, 1);
    if (abort_wait) begin
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_spur = 0;
      m_err = 1'b0;
      check_reset_outputs("abort");
      eoi = 1'b1;
      step();
      eoi = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("abort_no_put", a_valid, 0);
        step();
      end
      return;
    end
    for (int i = 0; i < e_dly; i++) begin
      step();
      chk("wait_eoi_no_put", a_valid, 0);
    end
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check_a("put", TL_PUT_FULL, {idv, 32'h0});
    for (int i = 0; i < a_dly; i++) begin
      step();
      check_a("put_hold", TL_PUT_FULL, {idv, 32'h0});
    end
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    chk("put_single", a_valid, 0);
    chk("cmpl_d_ready", d_ready, 1);
    d_valid = 1'b1;
    d_bits_opcode = TL_ACK;
    d_bits_data = '0;
    d_bits_denied = put_den;
    step();
    d_valid = 1'b0;
    d_bits_denied = 1'b0;
    if (put_den) m_err = 1'b1;
    chk("cmpl_done_busy", busy, 0);
    chk("cmpl_err_denied", err_denied, 64'(m_err));
    chk("cmpl_a_valid", a_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit dlv;
    reset = 1'b1; enable = 1'b0; int_in = 1'b0; a_ready = 1'b0;
    d_valid = 1'b0; d_bits_opcode = '0; d_bits_denied = 1'b0; d_bits_data = '0;
    id_ready = 1'b0; eoi = 1'b0;

    tbl[0] = '{32'd5,          1'b0, 0, 0, 0, 1'b1, 8'd0, 1'b0};
    tbl[1] = '{32'd0,          1'b0, 0, 0, 0, 1'b0, 8'd1, 1'b0};
    tbl[2] = '{32'd7,          1'b0, 7, 0, 1, 1'b1, 8'd1, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF,  1'b0, 2, 3, 2, 1'b1, 8'd1, 1'b0};
    tbl[4] = '{32'd0,          1'b0, 1, 1, 0, 1'b0, 8'd2, 1'b0};
    tbl[5] = '{32'd3,          1'b1, 0, 2, 0, 1'b0, 8'd2, 1'b1};
    tbl[6] = '{32'd0,          1'b0, 0, 0, 0, 1'b0, 8'd3, 1'b1};

    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    foreach (tbl[i]) begin
      run_claim(tbl[i].idv, tbl[i].den, tbl[i].a_dly, tbl[i].d_dly, tbl[i].c_dly,
                tbl[i].c_dly, 1'b0, 1'b0, dlv);
      chk("tbl_deliver", dlv, tbl[i].exp_deliver);
      chk("tbl_spur", spurious_cnt, tbl[i].exp_spur);
      chk("tbl_err", err_denied, tbl[i].exp_err);
    end

    // Disarmed sequencer and a stray eoi in IDLE must both be ignored
    enable = 1'b0;
    int_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eoi = (i == 1);
      step();
      chk("disabled_busy", busy, 0);
      chk("disabled_a_valid", a_valid, 0);
    end
    int_in = 1'b0;
    eoi = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic [31:0] r_idv;
      r_idv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_claim(r_idv, ($urandom_range(0, 9) == 0), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'b0, dlv);
      repeat ($urandom_range(0, 2)) step();
    end

    run_claim(32'd9, 1'b0, 1, 1, 1, 0, 1'b0, 1'b1, dlv);

    for (int n = 0; n < 300; n++) begin
      run_claim(32'd0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, dlv);
    end
    chk("spur_saturated", spurious_cnt, 255);

`ifdef PLIC_CLAIM_SEQ_TIMEOUT_EN
    int_in = 1'b1;
    step();
    int_in = 1'b0;
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk("wd_not_yet", err_timeout, 0);
      chk("wd_still_waiting", d_ready, 1);
    end
    step();
    chk("wd_fired", err_timeout, 1);
    chk("wd_idle", busy, 0);
    step();
    chk("wd_sticky", err_timeout, 1);
`else
    int_in = 1'b1;
    step();
    int_in = 1'b0;
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    repeat (40) step();
    chk("no_wd_err", err_timeout, 0);
    chk("no_wd_waiting", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("no_wd_reset_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
